// File: rtl/hazard_unit.sv
// hazard_unit: EX/MEM/WB hazard tracking with forwarding selects, load-use stall FSM and saturating stall counter
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_num,
  input  logic [4:0]       id_rs2_num,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_load_regfile,
  input  logic             id_is_load,
  output logic             hazard_mem_exec [2],
  output logic             hazard_wb_exec [2],
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;
  typedef enum logic {RUN, STALL} state_t;
  slot_t      ex, mem, wb;
  logic [4:0] ex_rs [2];
  logic       ex_use [2];
  state_t     state, state_n;
  logic       luse;
  function automatic logic writer(slot_t s);
    return s.valid && s.wr && s.rd != 5'd0;
  endfunction
  always_comb begin
    luse = writer(ex) && ex.ld && id_valid &&
           ((id_uses_rs1 && id_rs1_num == ex.rd) || (id_uses_rs2 && id_rs2_num == ex.rd));
    stall_out = state == RUN && luse && !flush;
    state_n = advance ? (stall_out ? STALL : RUN) : state;
    for (int i = 0; i < 2; i++) begin
      hazard_mem_exec[i] = writer(mem) && ex.valid && ex_use[i] && mem.rd == ex_rs[i];
      hazard_wb_exec[i]  = !hazard_mem_exec[i] && writer(wb) && ex.valid && ex_use[i] && wb.rd == ex_rs[i];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex          <= '0;
      mem         <= '0;
      wb          <= '0;
      ex_rs[0]    <= '0;
      ex_rs[1]    <= '0;
      ex_use[0]   <= 1'b0;
      ex_use[1]   <= 1'b0;
      state       <= RUN;
      stall_count <= '0;
    end else if (advance) begin
      wb          <= mem;
      mem         <= ex;
      ex          <= (stall_out || flush) ? '0 : slot_t'{id_valid, id_rd, id_load_regfile, id_is_load};
      ex_rs[0]    <= id_rs1_num;
      ex_rs[1]    <= id_rs2_num;
      ex_use[0]   <= id_uses_rs1;
      ex_use[1]   <= id_uses_rs2;
      state       <= state_n;
      stall_count <= (stall_out && !(&stall_count)) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed load-use/forwarding scenarios checked against a pipeline-history model
module tb_hazard_unit;
  logic        clk = 0;
  logic        reset, advance, flush, id_valid;
  logic [4:0]  id_rs1_num, id_rs2_num, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_load_regfile, id_is_load;
  logic        hm [2], hw [2], hm2 [2], hw2 [2];
  logic        stall, stall2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush), .id_valid(id_valid),
    .id_rs1_num(id_rs1_num), .id_rs2_num(id_rs2_num), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_load_regfile(id_load_regfile),
    .id_is_load(id_is_load), .hazard_mem_exec(hm), .hazard_wb_exec(hw),
    .stall_out(stall), .stall_count(cnt)
  );

  hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush), .id_valid(id_valid),
    .id_rs1_num(id_rs1_num), .id_rs2_num(id_rs2_num), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_load_regfile(id_load_regfile),
    .id_is_load(id_is_load), .hazard_mem_exec(hm2), .hazard_wb_exec(hw2),
    .stall_out(stall2), .stall_count(cnt2)
  );

  // Model: history of the last three issued entries, index 0 = EX, 1 = MEM, 2 = WB
  logic       mv [3], mwr [3], mld [3];
  logic [4:0] mrd [3];
  logic [4:0] mrs [2];
  logic       mu [2];
  logic       mst;
  int         mcount;

  function automatic logic m_writer(int k);
    return mv[k] && mwr[k] && mrd[k] != 5'd0;
  endfunction
  function automatic logic m_luse();
    return m_writer(0) && mld[0] && id_valid &&
           ((id_uses_rs1 && id_rs1_num == mrd[0]) || (id_uses_rs2 && id_rs2_num == mrd[0]));
  endfunction
  function automatic logic m_stall();
    return !mst && m_luse() && !flush;
  endfunction
  // youngest older producer of EX source i: 1 = MEM, 2 = WB, 0 = none
  function automatic int m_src(int i);
    for (int k = 1; k < 3; k++)
      if (mv[0] && mu[i] && m_writer(k) && mrd[k] == mrs[i]) return k;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) mv[k] <= 1'b0;
      mu[0] <= 1'b0;
      mu[1] <= 1'b0;
      mst <= 1'b0;
      mcount <= 0;
    end else if (advance) begin
      for (int k = 1; k < 3; k++) begin
        mv[k] <= mv[k-1]; mrd[k] <= mrd[k-1]; mwr[k] <= mwr[k-1]; mld[k] <= mld[k-1];
      end
      mv[0]  <= id_valid && !(m_stall() || flush);
      mrd[0] <= id_rd; mwr[0] <= id_load_regfile; mld[0] <= id_is_load;
      mrs[0] <= id_rs1_num; mrs[1] <= id_rs2_num;
      mu[0]  <= id_uses_rs1; mu[1] <= id_uses_rs2;
      mst    <= m_stall();
      if (m_stall() && mcount < 65535) mcount <= mcount + 1;
    end
  end

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("stall_out", stall, m_stall());
      chk("stall_out_w2", stall2, m_stall());
      chk("stall_count", cnt, mcount);
      chk("stall_count_w2", cnt2, mcount > 3 ? 3 : mcount);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mem_exec[%0d]", i), hm[i], m_src(i) == 1);
        chk($sformatf("wb_exec[%0d]", i), hw[i], m_src(i) == 2);
        chk($sformatf("mem_exec_w2[%0d]", i), hm2[i], m_src(i) == 1);
        chk($sformatf("wb_exec_w2[%0d]", i), hw2[i], m_src(i) == 2);
      end
    end
  end

  task automatic put(logic v, logic [4:0] rd, logic [4:0] rs1, logic u1,
                     logic [4:0] rs2, logic u2, logic wr, logic ld);
    id_valid = v; id_rd = rd; id_rs1_num = rs1; id_uses_rs1 = u1;
    id_rs2_num = rs2; id_uses_rs2 = u2; id_load_regfile = wr; id_is_load = ld;
    #1;
  endtask
  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    nop();
    repeat (3) tick();
  endtask
  task automatic load_use();
    put(1, 3, 1, 1, 0, 0, 1, 1);
    tick();
    put(1, 4, 3, 1, 3, 1, 1, 0);
    tick();
    tick();
    drain();
  endtask
  task automatic hz(string n, logic m0, logic m1, logic w0, logic w1);
    chk({n, "_mem0"}, hm[0], m0);
    chk({n, "_mem1"}, hm[1], m1);
    chk({n, "_wb0"}, hw[0], w0);
    chk({n, "_wb1"}, hw[1], w1);
  endtask

  initial begin
    reset = 1; advance = 1; flush = 0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_count", cnt, 0);
    hz("rst", 0, 0, 0, 0);
    reset = 0;
    // ALU chain: add x5 ; add x6,x5,x1
    put(1, 5, 1, 1, 2, 1, 1, 0); tick();
    put(1, 6, 5, 1, 1, 1, 1, 0); tick();
    nop();
    hz("alu_chain", 1, 0, 0, 0);
    chk("alu_chain_stall", stall, 0);
    drain();
    // distance two through rs2
    put(1, 7, 1, 1, 2, 1, 1, 0); tick();
    put(1, 8, 10, 1, 11, 1, 1, 0); tick();
    put(1, 12, 13, 1, 7, 1, 1, 0); tick();
    nop();
    hz("dist2", 0, 0, 0, 1);
    drain();
    // same pattern writing x0
    put(1, 0, 1, 1, 2, 1, 1, 0); tick();
    put(1, 8, 10, 1, 11, 1, 1, 0); tick();
    put(1, 12, 0, 1, 0, 1, 1, 0); tick();
    nop();
    hz("x0", 0, 0, 0, 0);
    drain();
    // load-use: lw x3 ; add x4,x3,x3
    put(1, 3, 1, 1, 0, 0, 1, 1); tick();
    put(1, 4, 3, 1, 3, 1, 1, 0);
    chk("lu_stall", stall, 1);
    chk("lu_count0", cnt, 0);
    tick();
    chk("lu_count1", cnt, 1);
    chk("lu_release", stall, 0);
    hz("lu_bubble", 0, 0, 0, 0);
    tick();
    nop();
    hz("lu_consumer", 0, 0, 1, 1);
    chk("lu_consumer_stall", stall, 0);
    drain();
    // double hit on x9
    put(1, 9, 1, 1, 2, 1, 1, 0); tick();
    put(1, 9, 1, 1, 2, 1, 1, 0); tick();
    put(1, 10, 9, 1, 0, 0, 1, 0); tick();
    nop();
    hz("double", 1, 0, 0, 0);
    drain();
    // load-use held by advance=0
    put(1, 3, 1, 1, 0, 0, 1, 1); tick();
    advance = 0;
    put(1, 4, 3, 1, 3, 1, 1, 0);
    repeat (3) begin
      chk("hold_stall", stall, 1);
      chk("hold_count", cnt, 1);
      tick();
    end
    advance = 1;
    #1;
    chk("hold_stall_adv", stall, 1);
    tick();
    chk("hold_count_adv", cnt, 2);
    chk("hold_release", stall, 0);
    tick();
    drain();
    // flush alongside load-use
    put(1, 3, 1, 1, 0, 0, 1, 1); tick();
    flush = 1;
    put(1, 4, 3, 1, 3, 1, 1, 0);
    chk("flush_stall", stall, 0);
    tick();
    flush = 0;
    nop();
    hz("flush_bubble", 0, 0, 0, 0);
    chk("flush_count", cnt, 2);
    drain();
    // flush while stalled returns to RUN
    put(1, 3, 1, 1, 0, 0, 1, 1); tick();
    put(1, 4, 3, 1, 3, 1, 1, 0); tick();
    flush = 1;
    #1;
    tick();
    flush = 0;
    chk("flush_stall_count", cnt, 3);
    chk("sat_w2_3", cnt2, 3);
    drain();
    load_use();
    chk("count4", cnt, 4);
    chk("sat_w2_4", cnt2, 3);
    // async reset while in STALL with count 5
    put(1, 3, 1, 1, 0, 0, 1, 1); tick();
    put(1, 4, 3, 1, 3, 1, 1, 0); tick();
    chk("pre_rst_count", cnt, 5);
    #1;
    reset = 1;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_count", cnt, 0);
    chk("arst_count_w2", cnt2, 0);
    hz("arst", 0, 0, 0, 0);
    tick();
    reset = 0;
    // first advance after reset loads EX normally
    put(1, 5, 1, 1, 2, 1, 1, 0); tick();
    put(1, 6, 5, 1, 1, 1, 1, 0); tick();
    nop();
    hz("post_rst", 1, 0, 0, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
